// File: rtl/seg_pkg.sv
// Shared definitions for the 8-digit 7-segment scan controller:
// digit count, field widths, the blanked anode pattern, the scan state
// type and the active-low one-hot anode select helper.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int POS_W      = 3;
  localparam int DIG_W      = 4;

  // All anodes off (common anode, active-low selects)
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

  // BLANK = anti-ghosting gap at slot start, SHOW = digit lit
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Active-low select: all ones except the bit at position p
  function automatic logic [NUM_DIGITS-1:0] onehot_low(input logic [POS_W-1:0] p);
    logic [NUM_DIGITS-1:0] sel;
    sel    = '0;
    sel[p] = 1'b1;
    return ~sel;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between the host side (digit/mask writes) and the scan controller,
// plus the display-facing outputs feeding the decode path and anodes.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                  wr_en;
  logic [POS_W-1:0]      wr_addr;
  logic [DIG_W-1:0]      wr_data;
  logic                  mask_we;
  logic [NUM_DIGITS-1:0] mask_data;

  logic [DIG_W-1:0]      dig;
  logic [POS_W-1:0]      pos;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_tick;

  // Host / environment side: drives writes, observes display outputs
  modport master (
    output wr_en, wr_addr, wr_data, mask_we, mask_data,
    input  dig, pos, an, frame_tick
  );

  // Scan controller side
  modport slave (
    input  wr_en, wr_addr, wr_data, mask_we, mask_data,
    output dig, pos, an, frame_tick
  );

endinterface

// File: rtl/scan_tick_gen.sv
// Slot timing for the scan controller: a free-running cycle counter that
// wraps every SCAN_DIV cycles, with a slot-boundary pulse on the last
// cycle of each slot and a blank-end pulse on the last blanked cycle.
// With BLANK_CYC = 0 there is no gap to end, so blank-end is held high and
// any BLANK state is left on the very next edge.
module scan_tick_gen #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 2_000,
  parameter int CNT_W     = 32
) (
  input  logic clk,
  input  logic rst,
  output logic o_slot_end,
  output logic o_blank_end
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((BLANK_CYC == 0) ? 0 : (BLANK_CYC - 1));

  logic [CNT_W-1:0] r_cnt;
  logic             w_slot_end;
  logic             w_blank_end;

  assign w_slot_end = (r_cnt == LAST_CNT);

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign w_blank_end = 1'b1;
    end else begin : g_blank
      assign w_blank_end = (r_cnt == BLANK_END);
    end
  endgenerate

  // Slot cycle counter: 0..SCAN_DIV-1, wrapping at the slot boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_slot_end  = w_slot_end;
  assign o_blank_end = w_blank_end;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit active-low common-anode
// 7-segment array. Holds eight hex digit registers and an enable mask,
// steps the digit position once per slot and blanks all anodes for the
// first BLANK_CYC cycles of each slot. Every output is registered.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 2_000,
  parameter int CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  logic w_slot_end;
  logic w_blank_end;

  scan_tick_gen #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .CNT_W     (CNT_W)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .o_slot_end  (w_slot_end),
    .o_blank_end (w_blank_end)
  );

  scan_state_t           r_state;
  scan_state_t           w_state_next;
  logic [POS_W-1:0]      r_pos;
  logic [POS_W-1:0]      w_pos_next;
  logic [POS_W-1:0]      w_pos_inc;
  logic [DIG_W-1:0]      r_dig;
  logic [DIG_W-1:0]      w_dig_next;
  logic [NUM_DIGITS-1:0] r_an;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic                  r_frame_tick;
  logic                  w_frame_tick_next;
  logic [NUM_DIGITS-1:0] r_mask;
  logic [DIG_W-1:0]      r_digits [NUM_DIGITS];

  // 3-bit position naturally wraps 7 -> 0
  assign w_pos_inc = r_pos + 3'd1;

  // Next scan state, position, digit code, anode pattern and frame pulse
  always_comb begin
    w_state_next      = r_state;
    w_pos_next        = r_pos;
    w_dig_next        = r_dig;
    w_frame_tick_next = 1'b0;

    case (r_state)
      BLANK:   if (w_blank_end) w_state_next = SHOW;
      SHOW:    w_state_next = SHOW;
      default: w_state_next = BLANK;
    endcase

    if (w_slot_end) begin
      w_state_next      = (BLANK_CYC == 0) ? SHOW : BLANK;
      w_pos_next        = w_pos_inc;
      w_frame_tick_next = (r_pos == 3'd7);
      if (bus.wr_en && (bus.wr_addr == w_pos_inc)) begin
        w_dig_next = bus.wr_data;
      end else begin
        w_dig_next = r_digits[w_pos_inc];
      end
    end

    // The mask register as it stands now gates the upcoming anode pattern,
    // so a mask write shows up one edge after it is captured.
    if ((w_state_next == SHOW) && r_mask[w_pos_next]) begin
      w_an_next = onehot_low(w_pos_next);
    end else begin
      w_an_next = AN_OFF;
    end
  end

  // Scan state and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= BLANK;
      r_pos        <= '0;
      r_dig        <= '0;
      r_an         <= AN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pos        <= w_pos_next;
      r_dig        <= w_dig_next;
      r_an         <= w_an_next;
      r_frame_tick <= w_frame_tick_next;
    end
  end

  // Digit register file and enable mask; both writes are independent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digits[i] <= '0;
      end
      r_mask <= AN_OFF;
    end else begin
      if (bus.wr_en) begin
        r_digits[bus.wr_addr] <= bus.wr_data;
      end
      if (bus.mask_we) begin
        r_mask <= bus.mask_data;
      end
    end
  end

  assign bus.dig        = r_dig;
  assign bus.pos        = r_pos;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with SCAN_DIV=8. One instance uses
// BLANK_CYC=2, a second uses BLANK_CYC=0. Cycle n below means the cycle
// after n clock edges following reset release (cycle 0 has cnt=0, pos=0).
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  seg_scan_ctrl_if bus ();
  seg_scan_ctrl_if bus0 ();

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(0), .CNT_W(32)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // 10 time-unit clock; outputs are sampled on the falling edge
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 3'd0;
    bus.wr_data   = 4'h0;
    bus.mask_we   = 1'b0;
    bus.mask_data = 8'h00;
  endtask

  task automatic adv_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.an !== 8'hFF) begin fails++; $display("[TB] FAIL reset_an got=%h exp=ff", bus.an); end
    checks++;
    if (bus.pos !== 3'd0) begin fails++; $display("[TB] FAIL reset_pos got=%0d exp=0", bus.pos); end
    checks++;
    if (bus.dig !== 4'h0) begin fails++; $display("[TB] FAIL reset_dig got=%h exp=0", bus.dig); end
    checks++;
    if (bus.frame_tick !== 1'b0) begin fails++; $display("[TB] FAIL reset_tick got=%b exp=0", bus.frame_tick); end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_free_run();
    logic [2:0] p;
    logic [7:0] exp_an;
    logic       exp_ft;
    do_reset();
    for (int c = 0; c <= 130; c++) begin
      adv_to(c);
      p      = 3'((c / 8) % 8);
      exp_an = ((c % 8) < 2) ? 8'hFF : ~(8'h01 << p);
      exp_ft = (c > 0) && ((c % 64) == 0);
      checks++;
      if (bus.an !== exp_an) begin fails++; $display("[TB] FAIL free_an cyc=%0d got=%h exp=%h", c, bus.an, exp_an); end
      checks++;
      if (bus.pos !== p) begin fails++; $display("[TB] FAIL free_pos cyc=%0d got=%0d exp=%0d", c, bus.pos, p); end
      checks++;
      if (bus.frame_tick !== exp_ft) begin fails++; $display("[TB] FAIL free_tick cyc=%0d got=%b exp=%b", c, bus.frame_tick, exp_ft); end
      checks++;
      if (bus.dig !== 4'h0) begin fails++; $display("[TB] FAIL free_dig cyc=%0d got=%h exp=0", c, bus.dig); end
    end
  endtask

  task automatic test_digit_write();
    do_reset();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 4'hA;
    adv_to(1);
    bus.wr_addr = 3'd7; bus.wr_data = 4'hF;
    adv_to(2);
    bus.wr_en = 1'b0;
    adv_to(24);
    checks++;
    if (bus.dig !== 4'hA || bus.pos !== 3'd3) begin fails++; $display("[TB] FAIL wr_slot3 got=%h/%0d exp=a/3", bus.dig, bus.pos); end
    adv_to(27);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 4'h5;
    adv_to(28);
    bus.wr_en = 1'b0;
    checks++;
    if (bus.dig !== 4'hA) begin fails++; $display("[TB] FAIL wr_live_hold got=%h exp=a", bus.dig); end
    adv_to(31);
    checks++;
    if (bus.dig !== 4'hA) begin fails++; $display("[TB] FAIL wr_live_end got=%h exp=a", bus.dig); end
    adv_to(32);
    checks++;
    if (bus.dig !== 4'h0) begin fails++; $display("[TB] FAIL wr_slot4 got=%h exp=0", bus.dig); end
    adv_to(56);
    checks++;
    if (bus.dig !== 4'hF || bus.pos !== 3'd7) begin fails++; $display("[TB] FAIL wr_slot7 got=%h/%0d exp=f/7", bus.dig, bus.pos); end
    adv_to(63);
    checks++;
    if (bus.dig !== 4'hF) begin fails++; $display("[TB] FAIL wr_slot7_end got=%h exp=f", bus.dig); end
    adv_to(64);
    checks++;
    if (bus.dig !== 4'h0) begin fails++; $display("[TB] FAIL wr_slot0 got=%h exp=0", bus.dig); end
    adv_to(88);
    checks++;
    if (bus.dig !== 4'h5 || bus.pos !== 3'd3) begin fails++; $display("[TB] FAIL wr_next_frame got=%h/%0d exp=5/3", bus.dig, bus.pos); end
  endtask

  task automatic test_write_bypass();
    do_reset();
    adv_to(31);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 4'hC;
    adv_to(32);
    bus.wr_en = 1'b0;
    checks++;
    if (bus.dig !== 4'hC) begin fails++; $display("[TB] FAIL bypass_dig got=%h exp=c", bus.dig); end
    checks++;
    if (bus.pos !== 3'd4) begin fails++; $display("[TB] FAIL bypass_pos got=%0d exp=4", bus.pos); end
    adv_to(96);
    checks++;
    if (bus.dig !== 4'hC) begin fails++; $display("[TB] FAIL bypass_stored got=%h exp=c", bus.dig); end
  endtask

  task automatic test_mask();
    do_reset();
    bus.mask_we = 1'b1; bus.mask_data = 8'hF7;
    adv_to(1);
    bus.mask_we = 1'b0;
    adv_to(18);
    checks++;
    if (bus.an !== 8'hFB) begin fails++; $display("[TB] FAIL mask_slot2 got=%h exp=fb", bus.an); end
    for (int c = 24; c <= 31; c++) begin
      adv_to(c);
      checks++;
      if (bus.an !== 8'hFF) begin fails++; $display("[TB] FAIL mask_slot3 cyc=%0d got=%h exp=ff", c, bus.an); end
    end
    adv_to(32);
    checks++;
    if (bus.pos !== 3'd4 || bus.an !== 8'hFF) begin fails++; $display("[TB] FAIL mask_slot4_start got=%0d/%h exp=4/ff", bus.pos, bus.an); end
    adv_to(34);
    checks++;
    if (bus.an !== 8'hEF) begin fails++; $display("[TB] FAIL mask_slot4 got=%h exp=ef", bus.an); end
    adv_to(90);
    checks++;
    if (bus.an !== 8'hFF) begin fails++; $display("[TB] FAIL mask_pre_enable got=%h exp=ff", bus.an); end
    bus.mask_we = 1'b1; bus.mask_data = 8'hFF;
    adv_to(91);
    bus.mask_we = 1'b0;
    adv_to(92);
    checks++;
    if (bus.an !== 8'hF7) begin fails++; $display("[TB] FAIL mask_reenable got=%h exp=f7", bus.an); end
    adv_to(106);
    checks++;
    if (bus.an !== 8'hDF) begin fails++; $display("[TB] FAIL mask_slot5 got=%h exp=df", bus.an); end
    bus.mask_we = 1'b1; bus.mask_data = 8'hDF;
    adv_to(107);
    bus.mask_we = 1'b0;
    adv_to(108);
    checks++;
    if (bus.an !== 8'hFF) begin fails++; $display("[TB] FAIL mask_clear_mid got=%h exp=ff", bus.an); end
    adv_to(114);
    checks++;
    if (bus.an !== 8'hBF || bus.pos !== 3'd6) begin fails++; $display("[TB] FAIL mask_slot6 got=%h/%0d exp=bf/6", bus.an, bus.pos); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 4'h7;
    bus.mask_we = 1'b1; bus.mask_data = 8'h7F;
    adv_to(1);
    idle_inputs();
    adv_to(44);
    checks++;
    if (bus.an !== 8'hDF || bus.pos !== 3'd5) begin fails++; $display("[TB] FAIL arst_pre got=%h/%0d exp=df/5", bus.an, bus.pos); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.an !== 8'hFF) begin fails++; $display("[TB] FAIL arst_an got=%h exp=ff", bus.an); end
    checks++;
    if (bus.pos !== 3'd0 || bus.dig !== 4'h0) begin fails++; $display("[TB] FAIL arst_pos_dig got=%0d/%h exp=0/0", bus.pos, bus.dig); end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c <= 64; c++) begin
      adv_to(c);
      checks++;
      if (bus.frame_tick !== (c == 64)) begin fails++; $display("[TB] FAIL arst_tick cyc=%0d got=%b", c, bus.frame_tick); end
    end
    cyc = 64;
    adv_to(114);
    checks++;
    if (bus.dig !== 4'h0 || bus.pos !== 3'd6) begin fails++; $display("[TB] FAIL arst_reg6 got=%h/%0d exp=0/6", bus.dig, bus.pos); end
    adv_to(122);
    checks++;
    if (bus.an !== 8'h7F) begin fails++; $display("[TB] FAIL arst_mask got=%h exp=7f", bus.an); end
  endtask

  task automatic test_blank0();
    logic [7:0] exp_an;
    do_reset();
    for (int c = 1; c <= 130; c++) begin
      adv_to(c);
      exp_an = ~(8'h01 << 3'((c / 8) % 8));
      checks++;
      if (bus0.an !== exp_an) begin fails++; $display("[TB] FAIL blank0_an cyc=%0d got=%h exp=%h", c, bus0.an, exp_an); end
    end
  endtask

  initial begin
    bus0.wr_en     = 1'b0;
    bus0.wr_addr   = 3'd0;
    bus0.wr_data   = 4'h0;
    bus0.mask_we   = 1'b0;
    bus0.mask_data = 8'h00;
    idle_inputs();
    #3;
    test_reset();
    test_free_run();
    test_digit_write();
    test_write_bypass();
    test_mask();
    test_async_reset();
    test_blank0();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
